hazard_forward_scoreboard: RTL and testbench
============================================

Name: hazard_forward_scoreboard

Overview:
- Parametrised successor to the EX-stage forwarding unit. Tracks in-flight destination registers internally instead of taking per-stage Rd/WE inputs.
- Sits at the ID/EX boundary. Produces registered per-port forward selects for the instruction entering EX, for NUM_READ_PORTS source operands.
- Generates the load-use stall and tracks one long-latency op (MUL/DIV) in a scoreboard, stalling dependent decodes until it completes.
- Youngest-producer priority is a requirement.

Parameters:
- NUM_READ_PORTS, 2, number of source operands per instruction.
- REG_ADDR_W, 5, register address width.
- FWD_STAGES, 2, number of forwarding sources downstream of EX (1=EX/MEM, 2=MEM/WB, ...).
- LONG_LAT, 4, cycles from long-op issue to its writeback; must be >= 1.
- SEL_W, localparam, $clog2(FWD_STAGES+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- holdPipeline  in  1  global freeze (memory wait); pipe and selects hold
- issueValid  in  1  valid instruction in decode
- issueRd  in  REG_ADDR_W  decode destination
- issueWe  in  1  decode writes register file
- issueIsLoad  in  1  decode is a load
- issueIsLong  in  1  decode is a long-latency op
- presentRs  in  NUM_READ_PORTS*REG_ADDR_W  decode sources, port p at [p*REG_ADDR_W +: REG_ADDR_W]
- forwardSelect  out  NUM_READ_PORTS*SEL_W  registered select for EX operands; 0=regfile, k=stage k
- stallDecode  out  1  combinational; decode must hold, a bubble enters EX
- longBusy  out  1  long op in flight
- longDoneValid  out  1  one-cycle pulse at long-op completion
- longDoneRd  out  REG_ADDR_W  destination of the completing long op
- loadUseStallCount  out  32  statistics; see optional feature
- longStallCount  out  32  statistics; see optional feature

Behaviour:
- Internal pipe, entries 0..FWD_STAGES. Each entry holds {we, isLoad, rd}; entry 0 is the instruction in EX.
- Advance when !holdPipeline: entry k+1<=entry k. Entry 0 <= decode instruction if issueValid && !stallDecode, else a bubble (we=0). The oldest entry drops.
- A long op enters the pipe with we=0, because its result is written back separately and is never forwarded.
- Match for port p at entry k: entry.we && entry.rd!=0 && entry.rd==rs[p].
- Select: the smallest k in 0..FWD_STAGES-1 that matches gives select value k+1 (youngest wins). No match gives 0.
- Select is registered on advance. If stallDecode on advance, the select registers load 0. holdPipeline holds them.
- Load-use: entry 0 matches any port with isLoad=1, so stallDecode=1.
- Long hazard: longBusy && issueValid, and either any rs[p]==busyRd (rs!=0), issueRd==busyRd with issueWe, or issueIsLong. Any of these gives stallDecode=1.
- stallDecode is the OR of the load-use and long-hazard terms and is 0 when !issueValid.
- Long tracker, issue (advance with issueValid && issueIsLong && !stallDecode): busyRd<=issueRd, counter<=LONG_LAT, longBusy<=1.
- Long tracker, run: the counter decrements every cycle, independent of holdPipeline.
- Long tracker, completion: on the 1->0 transition, longBusy<=0 and longDoneValid pulses for one cycle with longDoneRd=busyRd. A new long op may issue in the completion cycle.
- Reset: all pipe we=0, forwardSelect=0, longBusy=0, counter=0, longDoneValid=0, longDoneRd=0, stats=0. Reset mid-operation abandons any long op with no done pulse.
- rd/rs of x0 never create a match or a stall.

Optional Feature:
- Macro HAZARD_FWD_STATS_EN.
- Defined: loadUseStallCount increments each cycle with a load-use stall and !holdPipeline. longStallCount increments likewise for long-hazard stalls. Both counters saturate at 2^32-1.
- Undefined: no counter logic; both outputs tied to 0.

Decomposition:
- Package hazard_pkg: FWD_REGFILE=0 constant, pipe_entry_t struct {we, isLoad, rd}, stall-cause enum {NONE, LOAD_USE, LONG}.
- One sub-module, long_op_tracker: counter, busyRd and done pulse, parametrised by LONG_LAT and REG_ADDR_W.

Test Plan:
- ADD x5 issued, then SUB rs1=x5. The next cycle gives forwardSelect port0=1. One instruction later, a reader of x5 gets 2. A third later gets 0.
- Two back-to-back writers of x7, then reader rs2=x7. Port1 gets 1 (youngest), not 2.
- LW x3 issued, then ADD rs1=x3. stallDecode=1 for exactly one cycle, the bubble enters EX, then port0=2.
- MUL x9 with LONG_LAT=4, then ADD rs2=x9. Stall lasts 4 cycles, longDoneValid pulses with longDoneRd=9, then the issue proceeds with select 0.
- Writer x0 then reader x0: no forward, no stall. holdPipeline=1 for 3 cycles holds forwardSelect while the long counter still decrements.
- Reset asserted mid-long-op (counter=2): longBusy=0 the next cycle, no longDoneValid, and with the macro on the stat counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Optional statistics are enabled by defining HAZARD_FWD_STATS_EN.
package hazard_pkg;

   // Select value meaning "take the operand from the register file".
   localparam int unsigned FWD_REGFILE = 0;

   // Widest register address carried in a pipe entry; narrower addresses are zero-extended.
   localparam int unsigned RD_MAX_W = 8;

   // One in-flight instruction as seen by the forwarding logic.
   typedef struct packed {
      logic                we;
      logic                is_load;
      logic [RD_MAX_W-1:0] rd;
   } pipe_entry_t;

   // Reason the decode stage is being held.
   typedef enum logic [1:0] {
      STALL_NONE,
      STALL_LOAD_USE,
      STALL_LONG
   } stall_cause_e;

endpackage

// File: rtl/hazard_forward_scoreboard_long_op_tracker.sv
// Tracks a single in-flight long-latency op (MUL/DIV): destination,
// countdown to writeback and a one-cycle completion pulse.
module long_op_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned LONG_LAT   = 4,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  busy,
   output logic [REG_ADDR_W-1:0] busy_rd,
   output logic                  done_valid,
   output logic [REG_ADDR_W-1:0] done_rd
);

   localparam int unsigned CNT_W = $clog2(LONG_LAT + 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  done_q, done_d;
   logic [REG_ADDR_W-1:0] done_rd_q, done_rd_d;

   // Load on issue, otherwise count down and pulse done on the 1->0 step.
   always_comb begin
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      rd_d      = rd_q;
      done_d    = 1'b0;
      done_rd_d = done_rd_q;
      if (issue) begin
         cnt_d  = CNT_W'(LONG_LAT);
         busy_d = 1'b1;
         rd_d   = issue_rd;
      end else if (busy_q) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            done_rd_d = rd_q;
         end
      end
   end

   // Tracker state; reset abandons any op without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         rd_q      <= '0;
         done_q    <= 1'b0;
         done_rd_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         rd_q      <= rd_d;
         done_q    <= done_d;
         done_rd_q <= done_rd_d;
      end
   end

   assign busy       = busy_q;
   assign busy_rd    = rd_q;
   assign done_valid = done_q;
   assign done_rd    = done_rd_q;

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// ID/EX forwarding-select generator with internal in-flight destination
// tracking, load-use stall and single long-op scoreboard.
// Define HAZARD_FWD_STATS_EN to enable the stall statistics counters.
module hazard_forward_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_READ_PORTS = 2,
   parameter int unsigned REG_ADDR_W     = 5,
   parameter int unsigned FWD_STAGES     = 2,
   parameter int unsigned LONG_LAT       = 4,
   localparam int unsigned SEL_W         = $clog2(FWD_STAGES + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             holdPipeline,
   input  logic                             issueValid,
   input  logic [REG_ADDR_W-1:0]            issueRd,
   input  logic                             issueWe,
   input  logic                             issueIsLoad,
   input  logic                             issueIsLong,
   input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] presentRs,
   output logic [NUM_READ_PORTS*SEL_W-1:0]  forwardSelect,
   output logic                             stallDecode,
   output logic                             longBusy,
   output logic                             longDoneValid,
   output logic [REG_ADDR_W-1:0]            longDoneRd,
   output logic [31:0]                      loadUseStallCount,
   output logic [31:0]                      longStallCount
);

   // REG_ADDR_W must not exceed RD_MAX_W.
   pipe_entry_t pipe_q [FWD_STAGES+1];
   pipe_entry_t pipe_d [FWD_STAGES+1];

   logic [NUM_READ_PORTS-1:0][SEL_W-1:0] sel_q, sel_d;

   logic                  load_use;
   logic                  long_haz;
   logic                  stall;
   logic                  advance;
   logic                  long_issue;
   logic                  busy;
   logic [REG_ADDR_W-1:0] busy_rd;

   assign advance = !holdPipeline;

   // Hazard detection against the EX entry and the long-op scoreboard.
   always_comb begin
      logic [REG_ADDR_W-1:0] rs;
      load_use = 1'b0;
      long_haz = 1'b0;
      rs       = '0;
      for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
         rs = presentRs[p*REG_ADDR_W +: REG_ADDR_W];
         if (pipe_q[0].we && pipe_q[0].is_load && (pipe_q[0].rd != '0) &&
             (pipe_q[0].rd == RD_MAX_W'(rs)))
            load_use = 1'b1;
         if (busy && (rs != '0) && (rs == busy_rd))
            long_haz = 1'b1;
      end
      if (busy && issueWe && (issueRd != '0) && (issueRd == busy_rd))
         long_haz = 1'b1;
      if (busy && issueIsLong)
         long_haz = 1'b1;
      stall = issueValid && (load_use || long_haz);
   end

   assign stallDecode = stall;
   assign long_issue  = advance && issueValid && issueIsLong && !stall;

   // Pipe shift and youngest-match select computation.
   always_comb begin
      logic                  found;
      logic [REG_ADDR_W-1:0] rs;
      pipe_d = pipe_q;
      sel_d  = sel_q;
      found  = 1'b0;
      rs     = '0;
      if (advance) begin
         for (int unsigned k = 0; k < FWD_STAGES; k++)
            pipe_d[k+1] = pipe_q[k];
         pipe_d[0] = '0;
         if (issueValid && !stall) begin
            // Long ops write back outside the pipe, so they never forward.
            pipe_d[0].we      = issueWe && !issueIsLong;
            pipe_d[0].is_load = issueIsLoad;
            pipe_d[0].rd      = RD_MAX_W'(issueRd);
         end
         for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            rs       = presentRs[p*REG_ADDR_W +: REG_ADDR_W];
            found    = 1'b0;
            sel_d[p] = SEL_W'(FWD_REGFILE);
            if (!stall) begin
               for (int unsigned k = 0; k < FWD_STAGES; k++) begin
                  if (!found && pipe_q[k].we && (pipe_q[k].rd != '0) &&
                      (pipe_q[k].rd == RD_MAX_W'(rs))) begin
                     found    = 1'b1;
                     sel_d[p] = SEL_W'(k + 1);
                  end
               end
            end
         end
      end
   end

   // Pipe and select registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k <= FWD_STAGES; k++)
            pipe_q[k] <= '0;
         sel_q <= '0;
      end else begin
         pipe_q <= pipe_d;
         sel_q  <= sel_d;
      end
   end

   assign forwardSelect = sel_q;

   long_op_tracker #(
      .LONG_LAT   (LONG_LAT),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_long (
      .clk        (clk),
      .reset      (reset),
      .issue      (long_issue),
      .issue_rd   (issueRd),
      .busy       (busy),
      .busy_rd    (busy_rd),
      .done_valid (longDoneValid),
      .done_rd    (longDoneRd)
   );

   assign longBusy = busy;

`ifdef HAZARD_FWD_STATS_EN
   logic [31:0] lu_cnt_q, lu_cnt_d;
   logic [31:0] long_cnt_q, long_cnt_d;

   // Saturating stall counters, frozen while the pipeline is held.
   always_comb begin
      lu_cnt_d   = lu_cnt_q;
      long_cnt_d = long_cnt_q;
      if (advance && issueValid && load_use && (lu_cnt_q != '1))
         lu_cnt_d = lu_cnt_q + 32'd1;
      if (advance && issueValid && long_haz && (long_cnt_q != '1))
         long_cnt_d = long_cnt_q + 32'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         lu_cnt_q   <= '0;
         long_cnt_q <= '0;
      end else begin
         lu_cnt_q   <= lu_cnt_d;
         long_cnt_q <= long_cnt_d;
      end
   end

   assign loadUseStallCount = lu_cnt_q;
   assign longStallCount    = long_cnt_q;
`else
   assign loadUseStallCount = '0;
   assign longStallCount    = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed self-checking bench for hazard_forward_scoreboard (default parameters).
// Stat expectations follow HAZARD_FWD_STATS_EN.
module tb_hazard_forward_scoreboard;

   logic        clk;
   logic        reset;
   logic        holdPipeline;
   logic        issueValid;
   logic [4:0]  issueRd;
   logic        issueWe;
   logic        issueIsLoad;
   logic        issueIsLong;
   logic [9:0]  presentRs;
   logic [3:0]  forwardSelect;
   logic        stallDecode;
   logic        longBusy;
   logic        longDoneValid;
   logic [4:0]  longDoneRd;
   logic [31:0] loadUseStallCount;
   logic [31:0] longStallCount;

   int unsigned checks = 0;
   int unsigned errors = 0;

`ifdef HAZARD_FWD_STATS_EN
   localparam int unsigned STATS_ON = 1;
`else
   localparam int unsigned STATS_ON = 0;
`endif

   hazard_forward_scoreboard #(
      .NUM_READ_PORTS (2),
      .REG_ADDR_W     (5),
      .FWD_STAGES     (2),
      .LONG_LAT       (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .holdPipeline      (holdPipeline),
      .issueValid        (issueValid),
      .issueRd           (issueRd),
      .issueWe           (issueWe),
      .issueIsLoad       (issueIsLoad),
      .issueIsLong       (issueIsLong),
      .presentRs         (presentRs),
      .forwardSelect     (forwardSelect),
      .stallDecode       (stallDecode),
      .longBusy          (longBusy),
      .longDoneValid     (longDoneValid),
      .longDoneRd        (longDoneRd),
      .loadUseStallCount (loadUseStallCount),
      .longStallCount    (longStallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                        input logic ld, input logic lg,
                        input logic [4:0] rs0, input logic [4:0] rs1);
      issueValid  = v;
      issueRd     = rd;
      issueWe     = we;
      issueIsLoad = ld;
      issueIsLong = lg;
      presentRs   = {rs1, rs0};
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset        = 1'b1;
      holdPipeline = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      step();
      step();
      reset = 1'b0;
      check("reset_fwd", 32'(forwardSelect), 32'h0);
      check("reset_busy", 32'(longBusy), 32'h0);
      check("reset_done", 32'(longDoneValid), 32'h0);
      check("reset_done_rd", 32'(longDoneRd), 32'h0);
      check("reset_lu_cnt", loadUseStallCount, 32'h0);
      check("reset_long_cnt", longStallCount, 32'h0);

      // ADD x5, SUB x10 <- x5, reader x11 <- x5 (port1), reader x12 <- x5
      drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
      check("add_nostall", 32'(stallDecode), 32'h0);
      step();
      drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
      check("sub_nostall", 32'(stallDecode), 32'h0);
      step();
      check("fwd_exmem", 32'(forwardSelect), 32'h1);
      drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5);
      step();
      check("fwd_memwb_p1", 32'(forwardSelect), 32'h8);
      drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
      step();
      check("fwd_too_old", 32'(forwardSelect), 32'h0);

      // Two writers of x7 then reader rs2=x7: youngest wins
      drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7);
      step();
      check("youngest_wins", 32'(forwardSelect), 32'h4);

      // LW x3 then ADD x13 <- x3: one-cycle load-use stall
      drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
      check("lw_nostall", 32'(stallDecode), 32'h0);
      step();
      drive(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
      check("loaduse_stall", 32'(stallDecode), 32'h1);
      step();
      check("bubble_sel", 32'(forwardSelect), 32'h0);
      check("loaduse_release", 32'(stallDecode), 32'h0);
      step();
      check("loaduse_fwd", 32'(forwardSelect), 32'h2);

      // MUL x9 (LONG_LAT=4) then ADD x14 <- x9
      drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
      check("mul_nostall", 32'(stallDecode), 32'h0);
      step();
      check("mul_busy", 32'(longBusy), 32'h1);
      drive(1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 5'd0, 5'd9);
      for (int unsigned i = 0; i < 4; i++) begin
         check($sformatf("long_stall_%0d", i), 32'(stallDecode), 32'h1);
         check($sformatf("long_nodone_%0d", i), 32'(longDoneValid), 32'h0);
         step();
      end
      check("long_done", 32'(longDoneValid), 32'h1);
      check("long_done_rd", 32'(longDoneRd), 32'd9);
      check("long_idle", 32'(longBusy), 32'h0);
      check("long_release", 32'(stallDecode), 32'h0);
      step();
      check("long_done_pulse", 32'(longDoneValid), 32'h0);
      check("long_sel0", 32'(forwardSelect), 32'h0);
      check("lu_cnt", loadUseStallCount, 32'(STATS_ON * 1));
      check("long_cnt", longStallCount, 32'(STATS_ON * 4));

      // x0 writer/load never forwards or stalls
      drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      step();
      check("x0_nofwd", 32'(forwardSelect), 32'h0);
      drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check("x0_nostall", 32'(stallDecode), 32'h0);
      step();

      // Hold: selects freeze, long counter keeps running
      drive(1'b1, 5'd20, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd21, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd21, 5'd0);
      step();
      check("pre_hold_fwd", 32'(forwardSelect), 32'h1);
      holdPipeline = 1'b1;
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd21);
      step();
      check("hold_fwd_0", 32'(forwardSelect), 32'h1);
      check("hold_busy", 32'(longBusy), 32'h1);
      step();
      check("hold_fwd_1", 32'(forwardSelect), 32'h1);
      check("hold_done", 32'(longDoneValid), 32'h1);
      check("hold_done_rd", 32'(longDoneRd), 32'd20);
      step();
      check("hold_fwd_2", 32'(forwardSelect), 32'h1);
      holdPipeline = 1'b0;
      step();
      check("post_hold_fwd", 32'(forwardSelect), 32'h8);

      // Reset with the long counter at 2
      drive(1'b1, 5'd22, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check("rst_busy_4", 32'(longBusy), 32'h1);
      step();
      step();
      check("rst_busy_2", 32'(longBusy), 32'h1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy", 32'(longBusy), 32'h0);
      check("midrst_done", 32'(longDoneValid), 32'h0);
      step();
      check("midrst_done_after", 32'(longDoneValid), 32'h0);
      check("midrst_busy_after", 32'(longBusy), 32'h0);
      check("midrst_lu_cnt", loadUseStallCount, 32'h0);
      check("midrst_long_cnt", longStallCount, 32'h0);
      check("midrst_fwd", 32'(forwardSelect), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
